banner_scroll_render: RTL and testbench
=======================================

Name: banner_scroll_render

Overview:
Pixel-side consumer of the 1440-bit-wide text-banner ROM (6-bit row address, rows 1..41 valid; row 0 and rows above 41 return all-zero).
- Fetches one ROM row per scan line into a row register.
- Shifts a horizontal marquee offset once per N frames.
- Emits a pipelined foreground/background colour for every active pixel inside the banner window.
- Sits between the VGA timing generator and the final colour mux.

Parameters:
ROM_W, 1440, bits per ROM row; bit ROM_W-1 is the leftmost column.
ROM_ROWS, 41, number of valid ROM rows; they map to address 1..ROM_ROWS.
ORG_X, 0, screen x of banner window left edge.
ORG_Y, 400, screen y of ROM row 1.
WIN_W, 640, banner window width in pixels; must be <= ROM_W.
SCROLL_DIV, 2, frames per scroll step; must be >= 1.
SCROLL_STEP, 1, columns advanced per step; must be < ROM_W.
FG_RGB, 12'hFF0, colour for a set bit.
BG_RGB, 12'h000, colour for a clear bit inside the window.

Ports:
clk  in  1  pixel clock
rst_n  in  1  asynchronous active-low reset
frame_start  in  1  one-cycle pulse once per frame, during vertical blanking
line_start  in  1  one-cycle pulse per line, at least 3 cycles before that line's first de
line_y  in  11  screen y of the line announced by line_start; sampled with line_start
de  in  1  display enable for current pixel
x  in  11  screen x of current pixel
scroll_en  in  1  1 = marquee advances, 0 = frozen
rom_addr  out  6  address to the banner ROM
rom_data  in  1440  combinational ROM row data
pix_rgb  out  12  pixel colour
pix_in_win  out  1  pixel lies inside the banner window
pix_valid  out  1  de delayed to align with pix_rgb

Behaviour:
- Reset values: rom_addr=0, row_q=0, scroll=0, frame_cnt=0, pix_rgb=0, pix_in_win=0, pix_valid=0, all pipeline registers 0. Reset is honoured mid-line and mid-frame with no extra delay.
- Row fetch:
  - On line_start, compute r = line_y - ORG_Y + 1.
  - rom_addr <= r when ORG_Y <= line_y < ORG_Y+ROM_ROWS, else 0.
  - Set a 1-cycle fetch flag. The cycle after, row_q <= rom_data.
  - row_q stays constant for the entire line.
  - If line_start repeats before capture, the newer line_y wins.
- Scroll:
  - On frame_start with scroll_en=1: frame_cnt increments.
  - When frame_cnt reaches SCROLL_DIV-1: frame_cnt <= 0 and scroll <= scroll+SCROLL_STEP. If the sum >= ROM_W, subtract ROM_W (single compare-subtract).
  - scroll_en=0 holds both scroll and frame_cnt.
  - scroll only changes on frame_start, never mid-frame.
- Pixel pipeline, latency 2 clocks from x/de to outputs:
  - S1 computes:
    - in_win = de && (x >= ORG_X) && (x < ORG_X+WIN_W) && (rom_addr != 0).
    - col = (x-ORG_X) + scroll; if col >= ROM_W, col -= ROM_W. Width is 11 bits; the maximum sum 2*ROM_W-2 needs 12 bits internally.
    - Register in_win, col, de.
  - S2 computes:
    - bit = row_q[ROM_W-1-col].
    - pix_rgb <= (!de_d) ? 0 : (in_win_d ? (bit ? FG_RGB : BG_RGB) : BG_RGB).
    - pix_in_win <= in_win_d; pix_valid <= de_d.
- Column wrap is seamless: column ROM_W-1 is followed by column 0.
- x and line_y outside the window never index row_q; col is forced to 0 when not in_win.

Decomposition:
- Shared package `banner_pkg`: ROM_W, ROM_ROWS, ADDR_W=6, RGB_W=12, FG/BG default colours, XY_W=11.
- One natural sub-module: `banner_scroll_ctr`, holding the frame divider plus the mod-ROM_W scroll accumulator. The fetch logic and pixel pipeline stay in the top level.

Test Plan:
1. Reset release, line_start with line_y=400 -> rom_addr=1 next cycle; row_q equals ROM row 1 one cycle later.
2. line_y=399 and line_y=441 -> rom_addr=0; all pixels BG_RGB with pix_in_win=0.
3. Stub ROM row = MSB-only one-hot, scroll=0, de=1, x=0 -> pix_rgb=FG_RGB exactly 2 clocks later; x=1 -> BG_RGB; x=640 -> pix_in_win=0.
4. SCROLL_DIV=2, scroll_en=1, 5 frame_start pulses -> scroll=2. With scroll_en=0 for 3 further pulses -> scroll stays 2.
5. Force scroll=1439, x=1 -> col=0 selects row bit 1439; force scroll=1430 with SCROLL_STEP=10 -> wraps to 0.
6. Assert rst_n low mid-line with de=1 -> pix_rgb, pix_valid and scroll are 0 immediately (async). After release, output is correct on the first fully announced line.

Source files
------------

// File: rtl/banner_pkg.sv
// rtl/banner_pkg.sv - shared widths, colours and the mod-ROM_W column adder
package banner_pkg;
  localparam int ROM_W    = 1440;
  localparam int ROM_ROWS = 41;
  localparam int ADDR_W   = 6;
  localparam int RGB_W    = 12;
  localparam int XY_W     = 11;
  localparam int COL_W    = 11;

  localparam logic [RGB_W-1:0] FG_DEF = 12'hFF0;
  localparam logic [RGB_W-1:0] BG_DEF = 12'h000;

  localparam logic [COL_W:0]   ROM_W_X = 12'd1440;
  localparam logic [COL_W-1:0] ROM_MSB = 11'd1439;

  // Both operands are < ROM_W, so one compare-subtract keeps the result in range.
  function automatic logic [COL_W-1:0] wrap_add(input logic [COL_W-1:0] a,
                                                input logic [COL_W-1:0] b);
    logic [COL_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= ROM_W_X) s = s - ROM_W_X;
    return s[COL_W-1:0];
  endfunction
endpackage

// File: rtl/banner_scroll_render_if.sv
// rtl/banner_scroll_render_if.sv - timing, ROM and pixel signals of the banner renderer
interface banner_scroll_render_if;
  import banner_pkg::*;

  logic              frame_start;
  logic              line_start;
  logic [XY_W-1:0]   line_y;
  logic              de;
  logic [XY_W-1:0]   x;
  logic              scroll_en;
  logic [ADDR_W-1:0] rom_addr;
  logic [ROM_W-1:0]  rom_data;
  logic [RGB_W-1:0]  pix_rgb;
  logic              pix_in_win;
  logic              pix_valid;

  modport master (
    output frame_start, line_start, line_y, de, x, scroll_en, rom_data,
    input  rom_addr, pix_rgb, pix_in_win, pix_valid
  );

  modport slave (
    input  frame_start, line_start, line_y, de, x, scroll_en, rom_data,
    output rom_addr, pix_rgb, pix_in_win, pix_valid
  );
endinterface

// File: rtl/banner_scroll_ctr.sv
// rtl/banner_scroll_ctr.sv - frame divider and mod-ROM_W marquee offset
module banner_scroll_ctr
  import banner_pkg::*;
#(
  parameter int SCROLL_DIV  = 2,
  parameter int SCROLL_STEP = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_frame_start,
  input  logic             i_scroll_en,
  output logic [COL_W-1:0] o_scroll
);
  localparam int CNT_W = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCROLL_DIV - 1);
  localparam logic [COL_W-1:0] STEP_C   = COL_W'(SCROLL_STEP);

  logic [CNT_W-1:0] r_frame_cnt;
  logic [COL_W-1:0] r_scroll;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_frame_cnt <= '0;
      r_scroll    <= '0;
    end else if (i_frame_start && i_scroll_en) begin
      if (r_frame_cnt == CNT_LAST) begin
        r_frame_cnt <= '0;
        r_scroll    <= wrap_add(r_scroll, STEP_C);
      end else begin
        r_frame_cnt <= r_frame_cnt + CNT_W'(1);
      end
    end
  end

  assign o_scroll = r_scroll;
endmodule

// File: rtl/banner_scroll_render.sv
// rtl/banner_scroll_render.sv - per-line ROM row fetch and 2-stage banner pixel pipeline
module banner_scroll_render
  import banner_pkg::*;
#(
  parameter int               ORG_X       = 0,
  parameter int               ORG_Y       = 400,
  parameter int               WIN_W       = 640,
  parameter int               SCROLL_DIV  = 2,
  parameter int               SCROLL_STEP = 1,
  parameter logic [RGB_W-1:0] FG_RGB      = FG_DEF,
  parameter logic [RGB_W-1:0] BG_RGB      = BG_DEF
) (
  input logic                   clk,
  input logic                   rst_n,
  banner_scroll_render_if.slave bus
);
  localparam logic [XY_W-1:0] ORG_X_C = XY_W'(ORG_X);
  localparam logic [XY_W-1:0] ORG_Y_C = XY_W'(ORG_Y);
  localparam logic [XY_W-1:0] ROWS_C  = XY_W'(ROM_ROWS);
  localparam logic [XY_W-1:0] WIN_W_C = XY_W'(WIN_W);

  logic [ADDR_W-1:0] r_rom_addr;
  logic              r_fetch;
  logic [ROM_W-1:0]  r_row_q;
  logic [COL_W-1:0]  w_scroll;

  logic [XY_W-1:0]   w_rel_y;
  logic              w_row_hit;
  logic [XY_W-1:0]   w_xoff;
  logic              w_in_win;
  logic [COL_W-1:0]  w_col;
  logic              w_bit;

  logic              r_in_win_d;
  logic              r_de_d;
  logic [COL_W-1:0]  r_col_d;
  logic [RGB_W-1:0]  r_pix_rgb;
  logic              r_pix_in_win;
  logic              r_pix_valid;

  banner_scroll_ctr #(
    .SCROLL_DIV  (SCROLL_DIV),
    .SCROLL_STEP (SCROLL_STEP)
  ) u_ctr (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_frame_start (bus.frame_start),
    .i_scroll_en   (bus.scroll_en),
    .o_scroll      (w_scroll)
  );

  // Unsigned wrap turns "lo <= v < lo+n" into a single "v-lo < n" compare.
  assign w_rel_y   = bus.line_y - ORG_Y_C;
  assign w_row_hit = (w_rel_y < ROWS_C);
  assign w_xoff    = bus.x - ORG_X_C;
  assign w_in_win  = bus.de && (w_xoff < WIN_W_C) && (r_rom_addr != '0);
  assign w_col     = w_in_win ? wrap_add(w_xoff, w_scroll) : '0;
  assign w_bit     = r_row_q[ROM_MSB - r_col_d];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rom_addr <= '0;
      r_fetch    <= 1'b0;
      r_row_q    <= '0;
    end else begin
      r_fetch <= bus.line_start;
      if (bus.line_start)
        r_rom_addr <= w_row_hit ? ADDR_W'(w_rel_y + XY_W'(1)) : '0;
      if (r_fetch)
        r_row_q <= bus.rom_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_in_win_d   <= 1'b0;
      r_de_d       <= 1'b0;
      r_col_d      <= '0;
      r_pix_rgb    <= '0;
      r_pix_in_win <= 1'b0;
      r_pix_valid  <= 1'b0;
    end else begin
      r_in_win_d   <= w_in_win;
      r_de_d       <= bus.de;
      r_col_d      <= w_col;
      r_pix_in_win <= r_in_win_d;
      r_pix_valid  <= r_de_d;
      if (!r_de_d)
        r_pix_rgb <= '0;
      else
        r_pix_rgb <= (r_in_win_d && w_bit) ? FG_RGB : BG_RGB;
    end
  end

  assign bus.rom_addr   = r_rom_addr;
  assign bus.pix_rgb    = r_pix_rgb;
  assign bus.pix_in_win = r_pix_in_win;
  assign bus.pix_valid  = r_pix_valid;
endmodule

// File: tb/tb_banner_scroll_render.sv
// tb/tb_banner_scroll_render.sv - directed bench for banner_scroll_render
module tb_banner_scroll_render;
  import banner_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  banner_scroll_render_if b1();
  banner_scroll_render_if b2();

  banner_scroll_render dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b1.slave)
  );

  banner_scroll_render #(
    .SCROLL_DIV  (1),
    .SCROLL_STEP (10)
  ) dut2 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b2.slave)
  );

  // Stub ROM: row 1 = MSB only, row 2 = columns 5 and 1439, other valid rows one bit.
  function automatic logic [ROM_W-1:0] rom_row(input logic [ADDR_W-1:0] a);
    logic [ROM_W-1:0] r;
    r = '0;
    if (a == 6'd1) begin
      r[ROM_W-1] = 1'b1;
    end else if (a == 6'd2) begin
      r[ROM_W-1-5] = 1'b1;
      r[0] = 1'b1;
    end else if (a != 6'd0 && int'(a) <= ROM_ROWS) begin
      r[a] = 1'b1;
    end
    return r;
  endfunction

  always_comb b1.rom_data = rom_row(b1.rom_addr);
  always_comb b2.rom_data = rom_row(b2.rom_addr);

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_row(input string tag, input logic [ROM_W-1:0] obs, input logic [ROM_W-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s row register differs from ROM row", tag);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_line(input bit s, input bit ls, input int y);
    if (!s) begin b1.line_start = ls; b1.line_y = 11'(y); end
    else    begin b2.line_start = ls; b2.line_y = 11'(y); end
  endtask

  task automatic set_pix(input bit s, input bit de, input int xv);
    if (!s) begin b1.de = de; b1.x = 11'(xv); end
    else    begin b2.de = de; b2.x = 11'(xv); end
  endtask

  task automatic announce(input bit s, input int y);
    set_line(s, 1'b1, y);
    tick(1);
    set_line(s, 1'b0, y);
    tick(3);
  endtask

  task automatic pixel(input bit s, input int xv);
    set_pix(s, 1'b1, xv);
    tick(1);
    set_pix(s, 1'b0, 0);
    tick(1);
  endtask

  task automatic frames(input bit s, input int n, input bit en);
    repeat (n) begin
      if (!s) begin b1.frame_start = 1'b1; b1.scroll_en = en; end
      else    begin b2.frame_start = 1'b1; b2.scroll_en = en; end
      tick(1);
      if (!s) b1.frame_start = 1'b0; else b2.frame_start = 1'b0;
      tick(1);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    b1.frame_start = 0; b1.line_start = 0; b1.line_y = '0; b1.de = 0; b1.x = '0; b1.scroll_en = 0;
    b2.frame_start = 0; b2.line_start = 0; b2.line_y = '0; b2.de = 0; b2.x = '0; b2.scroll_en = 0;
    tick(3);
    chk("rst_rom_addr", b1.rom_addr, 0);
    chk("rst_pix_rgb", b1.pix_rgb, 0);
    chk("rst_pix_valid", b1.pix_valid, 0);
    chk("rst_pix_in_win", b1.pix_in_win, 0);
    chk("rst_scroll", dut.u_ctr.r_scroll, 0);
    rst_n = 1'b1;
    tick(1);

    set_line(0, 1'b1, 400);
    tick(1);
    set_line(0, 1'b0, 400);
    chk("fetch_addr_400", b1.rom_addr, 1);
    tick(1);
    chk_row("fetch_row1", dut.r_row_q, rom_row(6'd1));
    tick(2);

    set_pix(0, 1'b1, 0);
    tick(1);
    set_pix(0, 1'b0, 0);
    chk("lat_valid_1clk", b1.pix_valid, 0);
    tick(1);
    chk("x0_rgb_fg", b1.pix_rgb, 12'hFF0);
    chk("x0_in_win", b1.pix_in_win, 1);
    chk("x0_valid", b1.pix_valid, 1);
    pixel(0, 1);
    chk("x1_rgb_bg", b1.pix_rgb, 12'h000);
    chk("x1_in_win", b1.pix_in_win, 1);
    pixel(0, 639);
    chk("x639_in_win", b1.pix_in_win, 1);
    pixel(0, 640);
    chk("x640_in_win", b1.pix_in_win, 0);
    chk("x640_valid", b1.pix_valid, 1);
    tick(1);
    chk("de0_valid", b1.pix_valid, 0);

    announce(0, 401);
    pixel(0, 5);
    chk("row2_x5_fg", b1.pix_rgb, 12'hFF0);
    pixel(0, 4);
    chk("row2_x4_bg", b1.pix_rgb, 12'h000);

    announce(0, 399);
    chk("addr_399", b1.rom_addr, 0);
    pixel(0, 0);
    chk("y399_in_win", b1.pix_in_win, 0);
    chk("y399_rgb", b1.pix_rgb, 12'h000);
    announce(0, 441);
    chk("addr_441", b1.rom_addr, 0);
    announce(0, 440);
    chk("addr_440", b1.rom_addr, 41);

    set_line(0, 1'b1, 401);
    tick(1);
    set_line(0, 1'b1, 400);
    tick(1);
    set_line(0, 1'b0, 400);
    tick(2);
    chk("repeat_addr", b1.rom_addr, 1);
    chk_row("repeat_row", dut.r_row_q, rom_row(6'd1));

    frames(0, 5, 1'b1);
    chk("scroll_5f", dut.u_ctr.r_scroll, 2);
    chk("fcnt_5f", dut.u_ctr.r_frame_cnt, 1);
    frames(0, 3, 1'b0);
    chk("scroll_frozen", dut.u_ctr.r_scroll, 2);
    chk("fcnt_frozen", dut.u_ctr.r_frame_cnt, 1);

    announce(0, 401);
    pixel(0, 3);
    chk("scr2_x3_fg", b1.pix_rgb, 12'hFF0);
    pixel(0, 5);
    chk("scr2_x5_bg", b1.pix_rgb, 12'h000);

    set_pix(0, 1'b1, 3);
    tick(2);
    chk("pre_rst_valid", b1.pix_valid, 1);
    chk("pre_rst_rgb", b1.pix_rgb, 12'hFF0);
    rst_n = 1'b0;
    #1;
    chk("async_rst_rgb", b1.pix_rgb, 0);
    chk("async_rst_valid", b1.pix_valid, 0);
    chk("async_rst_scroll", dut.u_ctr.r_scroll, 0);
    tick(1);
    rst_n = 1'b1;
    set_pix(0, 1'b0, 0);
    tick(1);
    announce(0, 400);
    pixel(0, 0);
    chk("post_rst_x0_fg", b1.pix_rgb, 12'hFF0);
    chk("post_rst_in_win", b1.pix_in_win, 1);

    frames(1, 143, 1'b1);
    chk("d2_scroll_1430", dut2.u_ctr.r_scroll, 1430);
    announce(1, 400);
    pixel(1, 10);
    chk("d2_wrap_col0_fg", b2.pix_rgb, 12'hFF0);
    announce(1, 401);
    pixel(1, 9);
    chk("d2_col1439_fg", b2.pix_rgb, 12'hFF0);
    pixel(1, 10);
    chk("d2_col0_row2_bg", b2.pix_rgb, 12'h000);
    frames(1, 1, 1'b1);
    chk("d2_scroll_wrap0", dut2.u_ctr.r_scroll, 0);
    pixel(1, 5);
    chk("d2_scr0_x5_fg", b2.pix_rgb, 12'hFF0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
